delay_align_scheduler: RTL and testbench

//  Sequences automatic bit alignment across NUM_LINKS delay_ctrl lanes, one lane at a time.
//  For each enabled lane it raises delay_mode, waits for auto lock, lets tracking settle,

---
 rtl/delay_align_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_delay_align_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_align_scheduler.sv
// Sweeps automatic bit alignment across delay_ctrl lanes, one lane at a time,
// retrying lanes with a narrow eye and reporting per-lane pass/fail status.
module delay_align_scheduler #(
    parameter int NUM_LINKS     = 8,
    parameter int MIN_EYE       = 4,
    parameter int MAX_RETRY     = 3,
    parameter int ARM_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 1024,
    parameter int TIMEOUT_W     = 16
) (
    input  logic                   clk160,
    input  logic                   totalCounterResetb_manual,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_LINKS-1:0]   link_enable,
    input  logic [NUM_LINKS-1:0]   delay_ready,
    input  logic [6*NUM_LINKS-1:0] eye_width,
    output logic [NUM_LINKS-1:0]   delay_mode,
    output logic [6*NUM_LINKS-1:0] eye_width_latched,
    output logic [NUM_LINKS-1:0]   link_aligned,
    output logic [NUM_LINKS-1:0]   link_failed,
    output logic                   busy,
    output logic                   done
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int IW  = $clog2(NUM_LINKS + 1);
    localparam int LW  = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
    localparam int TCW = imax(imax(TIMEOUT_W, 2),
                              imax($clog2(SETTLE_CYCLES + 1), $clog2(ARM_CYCLES + 1)));

    localparam logic [TCW-1:0] T_ARM  = TCW'(ARM_CYCLES - 1);
    localparam logic [TCW-1:0] T_SET  = TCW'(SETTLE_CYCLES - 1);
    localparam logic [TCW-1:0] T_LOCK = TCW'((2 ** TIMEOUT_W) - 2);
    localparam logic [TCW-1:0] T_REL  = TCW'(3);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_ARM, S_WAIT, S_SETTLE, S_SAMPLE, S_RELEASE, S_DONE
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [LW-1:0]  lane;
    logic [TCW-1:0] timer;
    logic [2:0]     retry;
    logic [1:0]     start_q;
    logic           pass;
    logic           rel_seen;

    logic                 start_edge;
    logic                 last_lane;
    logic                 cur_ready;
    logic                 cur_en;
    logic                 eye_ok;
    logic [5:0]           cur_eye;
    logic [NUM_LINKS-1:0] lane_hot;

    assign lane       = idx[LW-1:0];
    assign start_edge = start_q[0] & ~start_q[1];
    assign last_lane  = (idx == IW'(NUM_LINKS));
    assign eye_ok     = (cur_eye >= 6'(MIN_EYE));

    always_comb begin
        cur_ready = 1'b0;
        cur_en    = 1'b0;
        cur_eye   = '0;
        lane_hot  = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            if (lane == LW'(i)) begin
                cur_ready   = delay_ready[i];
                cur_en      = link_enable[i];
                cur_eye     = eye_width[6*i +: 6];
                lane_hot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
        if (!totalCounterResetb_manual) begin
            state             <= S_IDLE;
            idx               <= '0;
            timer             <= '0;
            retry             <= '0;
            start_q           <= '0;
            pass              <= 1'b0;
            rel_seen          <= 1'b0;
            delay_mode        <= '0;
            eye_width_latched <= '0;
            link_aligned      <= '0;
            link_failed       <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            start_q <= {start_q[0], start};
            done    <= 1'b0;
            timer   <= timer + 1'b1;
            if (abort && state != S_IDLE && state != S_DONE) begin
                delay_mode <= '0;
                state      <= S_DONE;
                timer      <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start_edge && !abort) begin
                            link_aligned      <= '0;
                            link_failed       <= '0;
                            eye_width_latched <= '0;
                            idx               <= '0;
                            busy              <= 1'b1;
                            state             <= S_SELECT;
                            timer             <= '0;
                        end
                    end
                    S_SELECT: begin
                        timer <= '0;
                        if (last_lane) begin
                            state <= S_DONE;
                        end else if (!cur_en) begin
                            idx <= idx + 1'b1;
                        end else begin
                            retry      <= '0;
                            delay_mode <= lane_hot;
                            state      <= S_ARM;
                        end
                    end
                    // a stale ready from the previous run may still be high here
                    S_ARM: begin
                        if (timer == T_ARM) begin
                            state <= S_WAIT;
                            timer <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (cur_ready) begin
                            state <= S_SETTLE;
                            timer <= '0;
                        end else if (timer == T_LOCK) begin
                            pass       <= 1'b0;
                            rel_seen   <= 1'b0;
                            delay_mode <= '0;
                            state      <= S_RELEASE;
                            timer      <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (timer == T_SET) begin
                            state <= S_SAMPLE;
                            timer <= '0;
                        end
                    end
                    S_SAMPLE: begin
                        for (int i = 0; i < NUM_LINKS; i++) begin
                            if (lane == LW'(i))
                                eye_width_latched[6*i +: 6] <= cur_eye;
                        end
                        pass       <= eye_ok;
                        rel_seen   <= 1'b0;
                        delay_mode <= '0;
                        state      <= S_RELEASE;
                        timer      <= '0;
                    end
                    // manual ready, then 4 cycles so the lane can finish PHASE2_END
                    S_RELEASE: begin
                        if (!rel_seen) begin
                            if (cur_ready) begin
                                rel_seen <= 1'b1;
                                timer    <= '0;
                            end else if (timer == T_LOCK) begin
                                link_failed[lane] <= 1'b1;
                                idx               <= idx + 1'b1;
                                state             <= S_SELECT;
                                timer             <= '0;
                            end
                        end else if (timer == T_REL) begin
                            timer <= '0;
                            if (pass) begin
                                link_aligned[lane] <= 1'b1;
                                idx                <= idx + 1'b1;
                                state              <= S_SELECT;
                            end else if (retry < 3'(MAX_RETRY)) begin
                                retry      <= retry + 1'b1;
                                delay_mode <= lane_hot;
                                state      <= S_ARM;
                            end else begin
                                link_failed[lane] <= 1'b1;
                                idx               <= idx + 1'b1;
                                state             <= S_SELECT;
                            end
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                        timer <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delay_align_scheduler.sv
// Directed bench for delay_align_scheduler with a behavioural lane model
// that locks after a set number of auto-mode cycles.
module tb_delay_align_scheduler;

    localparam int N    = 4;
    localparam int ARM  = 4;
    localparam int SET  = 16;
    localparam int TW   = 8;
    localparam int MINE = 4;
    localparam int MAXR = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic [N-1:0]   en;
    logic [N-1:0]   rdy;
    logic [6*N-1:0] ew;
    logic [N-1:0]   dm;
    logic [6*N-1:0] lat_eye;
    logic [N-1:0]   aligned;
    logic [N-1:0]   failed;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    delay_align_scheduler #(
        .NUM_LINKS(N), .MIN_EYE(MINE), .MAX_RETRY(MAXR),
        .ARM_CYCLES(ARM), .SETTLE_CYCLES(SET), .TIMEOUT_W(TW)
    ) dut (
        .clk160(clk),
        .totalCounterResetb_manual(rst_n),
        .start(start),
        .abort(abort),
        .link_enable(en),
        .delay_ready(rdy),
        .eye_width(ew),
        .delay_mode(dm),
        .eye_width_latched(lat_eye),
        .link_aligned(aligned),
        .link_failed(failed),
        .busy(busy),
        .done(done)
    );

    int         lock_lat [N];
    logic [5:0] eye_v    [N];
    logic [N-1:0] force_hi;
    int         cnt      [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            cnt[i] <= dm[i] ? cnt[i] + 1 : 0;
    end

    always_comb begin
        rdy = '0;
        ew  = '0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = force_hi[i] | ~dm[i] |
                     ((lock_lat[i] != 0) && (cnt[i] >= lock_lat[i]));
            ew[6*i +: 6] = eye_v[i];
        end
    end

    int       done_tot = 0;
    int       viol = 0;
    int       rises [N];
    int       mode_hi [N];
    logic [N-1:0] prev_dm = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            rises[i]   = 0;
            mode_hi[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (done) done_tot = done_tot + 1;
        if ($countones(dm) > 1) viol = viol + 1;
        for (int i = 0; i < N; i++) begin
            if (dm[i] && !prev_dm[i]) rises[i] = rises[i] + 1;
            if (dm[i]) mode_hi[i] = mode_hi[i] + 1;
        end
        prev_dm = dm;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]      en;
        logic [3:0][7:0] lat;
        logic [3:0][5:0] eye;
        logic [3:0]      al;
        logic [3:0]      fl;
        logic [3:0][3:0] rs;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] e, input logic [31:0] l,
                                input logic [23:0] y, input logic [3:0] a,
                                input logic [3:0] f, input logic [15:0] r);
        vec_t v;
        v.en = e; v.lat = l; v.eye = y; v.al = a; v.fl = f; v.rs = r;
        return v;
    endfunction

    task automatic setup(input logic [3:0] e, input logic [31:0] l,
                         input logic [23:0] y, input logic [3:0] fh);
        en = e;
        force_hi = fh;
        for (int i = 0; i < N; i++) begin
            lock_lat[i] = int'(l[8*i +: 8]);
            eye_v[i]    = y[6*i +: 6];
        end
    endtask

    task automatic sweep(input string nm);
        int d0;
        d0 = done_tot;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20000 && done_tot == d0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({nm, " done_pulses"}, 64'(done_tot - d0), 64'd1);
        chk({nm, " busy_after"}, 64'(busy), 64'd0);
    endtask

    vec_t vec [5];
    logic [15:0] rs_got;
    int r0 [N];
    int m0;
    int d1;

    initial begin
        vec[0] = mk(4'b1111, {8'd100, 8'd100, 8'd100, 8'd100},
                    {6'd10, 6'd10, 6'd10, 6'd10}, 4'b1111, 4'b0000, 16'h1111);
        vec[1] = mk(4'b0101, {8'd100, 8'd100, 8'd100, 8'd100},
                    {6'd10, 6'd10, 6'd10, 6'd10}, 4'b0101, 4'b0000, 16'h0101);
        vec[2] = mk(4'b1111, {8'd100, 8'd100, 8'd100, 8'd100},
                    {6'd10, 6'd3, 6'd10, 6'd10}, 4'b1011, 4'b0100, 16'h1411);
        vec[3] = mk(4'b1111, {8'd100, 8'd100, 8'd100, 8'd0},
                    {6'd10, 6'd10, 6'd10, 6'd10}, 4'b1110, 4'b0001, 16'h1114);
        vec[4] = mk(4'b1111, {8'd60, 8'd60, 8'd60, 8'd60},
                    {6'd3, 6'd4, 6'd63, 6'd0}, 4'b0110, 4'b1001, 16'h4114);

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        setup(4'b0000, 32'h0, 24'h0, 4'b0000);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {dm, lat_eye, aligned, failed, busy, done}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            setup(vec[v].en, vec[v].lat, vec[v].eye, 4'b0000);
            for (int i = 0; i < N; i++) r0[i] = rises[i];
            sweep($sformatf("vec%0d", v));
            for (int i = 0; i < N; i++) rs_got[4*i +: 4] = 4'(rises[i] - r0[i]);
            chk($sformatf("vec%0d aligned", v), 64'(aligned), 64'(vec[v].al));
            chk($sformatf("vec%0d failed", v), 64'(failed), 64'(vec[v].fl));
            chk($sformatf("vec%0d rises", v), 64'(rs_got), 64'(vec[v].rs));
            for (int i = 0; i < N; i++)
                if (!vec[v].en[i]) vec[v].eye[i] = 6'd0;
            vec[v].eye[0] = (vec[v].lat[0] == 8'd0) ? 6'd0 : vec[v].eye[0];
            chk($sformatf("vec%0d latched", v), 64'(lat_eye), 64'(vec[v].eye));
        end

        // ready already high when ARM starts: SETTLE begins right after the window
        setup(4'b0001, {8'd100, 8'd100, 8'd100, 8'd100},
              {6'd10, 6'd10, 6'd10, 6'd10}, 4'b0001);
        m0 = mode_hi[0];
        sweep("stale");
        chk("stale mode_cycles", 64'(mode_hi[0] - m0), 64'(ARM + 1 + SET + 1));
        chk("stale aligned", 64'(aligned), 64'b0001);
        chk("stale latched", 64'(lat_eye[5:0]), 64'd10);
        force_hi = 4'b0000;

        d1 = done_tot;
        abort = 1'b1;
        start = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_abort busy", 64'(busy), 64'd0);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_abort no_start", 64'({busy, dm}), 64'd0);
        chk("idle_abort no_done", 64'(done_tot - d1), 64'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        setup(4'b1111, {8'd100, 8'd100, 8'd100, 8'd100},
              {6'd10, 6'd10, 6'd10, 6'd10}, 4'b0000);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5000 && dm != 4'b0010; k++) @(negedge clk);
        chk("abort reach_lane1", 64'(dm), 64'b0010);
        repeat (108) @(negedge clk);
        d1 = done_tot;
        abort = 1'b1;
        @(negedge clk);
        chk("abort mode_drop", 64'(dm), 64'd0);
        @(negedge clk);
        chk("abort done", 64'(done), 64'd1);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort status", 64'({aligned, failed, busy}), 64'({4'b0001, 4'b0000, 1'b0}));
        chk("abort done_count", 64'(done_tot - d1), 64'd1);

        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5000 && dm != 4'b0100; k++) @(negedge clk);
        chk("midreset reach_lane2", 64'({dm, aligned}), 64'({4'b0100, 4'b0011}));
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset outputs", {dm, lat_eye, aligned, failed, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("onehot_violations", 64'(viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
